if_pc_ctrl: RTL and testbench

IF_PC_CTRL -- requirements
Module: if_pc_ctrl

---
 rtl/if_pkg.sv | 23 ++
 rtl/if_pcadd.sv | 11 +
 rtl/if_pc_ctrl.sv | 125 ++++++++++++
 tb/tb_if_pc_ctrl.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/if_pkg.sv
// Shared types and constants for the instruction-fetch PC controller.
// The DSLOT state exists only when IF_DELAY_SLOT_EN is defined.
package if_pkg;

    localparam int unsigned ADDR_W      = 32;
    localparam int unsigned INSTR_BYTES = 4;

`ifdef IF_DELAY_SLOT_EN
    typedef enum logic [1:0] {
        StIdle,
        StFetch,
        StStall,
        StDslot
    } if_state_e;
`else
    typedef enum logic [1:0] {
        StIdle,
        StFetch,
        StStall
    } if_state_e;
`endif

endpackage

// File: rtl/if_pcadd.sv
// Sequential-PC adder: pc + INSTR_BYTES, wrapping modulo 2^ADDR_W.
module if_pcadd
    import if_pkg::*;
(
    input  logic [ADDR_W-1:0] pc_i,
    output logic [ADDR_W-1:0] pcadd4_o
);

    assign pcadd4_o = pc_i + ADDR_W'(INSTR_BYTES);

endmodule

// File: rtl/if_pc_ctrl.sv
// Fetch-stage PC sequencer: IDLE/FETCH/STALL FSM with stall hold, redirects and
// misaligned-target rejection. Define IF_DELAY_SLOT_EN for MIPS delay-slot sequencing.
module if_pc_ctrl
    import if_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_VECTOR = 32'h0000_0000
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_stall,
    input  logic              i_redirect,
    input  logic [ADDR_W-1:0] i_redirect_addr,
    output logic              o_imem_req,
    output logic [ADDR_W-1:0] o_imem_addr,
    input  logic              i_imem_ack,
    output logic              o_valid,
    output logic [ADDR_W-1:0] o_pc,
    output logic [ADDR_W-1:0] o_pcadd4,
    output logic              o_misaligned
);

    if_state_e         state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              mis_q, mis_d;
    logic [ADDR_W-1:0] pcadd4;
    logic              redir_ok, redir_bad, in_dslot, discard, req, valid;
`ifdef IF_DELAY_SLOT_EN
    logic [ADDR_W-1:0] target_q, target_d;
`endif

    if_pcadd u_pcadd (
        .pc_i     (pc_q),
        .pcadd4_o (pcadd4)
    );

    always_comb begin
        redir_ok  = i_redirect & (i_redirect_addr[1:0] == 2'b00);
        redir_bad = i_redirect & (i_redirect_addr[1:0] != 2'b00);
`ifdef IF_DELAY_SLOT_EN
        in_dslot  = (state_q == StDslot);
        discard   = 1'b0;
        req       = (state_q == StFetch) | (in_dslot & ~i_stall);
`else
        in_dslot  = 1'b0;
        // Without delay slots the in-flight instruction is on the wrong path.
        discard   = redir_ok;
        req       = (state_q == StFetch);
`endif
        req       = req & ~i_rst;
        valid     = i_imem_ack & req & ~i_stall & ~discard;
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        mis_d   = 1'b0;
`ifdef IF_DELAY_SLOT_EN
        target_d = target_q;
`endif
        if (i_rst) begin
            state_d = StIdle;
            pc_d    = RESET_VECTOR;
`ifdef IF_DELAY_SLOT_EN
            target_d = '0;
`endif
        end else if (redir_ok && !in_dslot) begin
`ifdef IF_DELAY_SLOT_EN
            // An instruction accepted alongside the redirect is itself the delay slot.
            if (valid) begin
                pc_d    = i_redirect_addr;
                state_d = StFetch;
            end else begin
                target_d = i_redirect_addr;
                state_d  = StDslot;
            end
`else
            pc_d    = i_redirect_addr;
            state_d = StFetch;
`endif
        end else begin
            mis_d = redir_bad & ~in_dslot;
            case (state_q)
                StIdle:  state_d = StFetch;
                StFetch: begin
                    if (i_stall) begin
                        state_d = StStall;
                    end else if (valid) begin
                        pc_d = pcadd4;
                    end
                end
                StStall: begin
                    if (!i_stall) begin
                        state_d = StFetch;
                    end
                end
`ifdef IF_DELAY_SLOT_EN
                StDslot: begin
                    if (valid) begin
                        pc_d    = target_q;
                        state_d = StFetch;
                    end
                end
`endif
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        state_q <= state_d;
        pc_q    <= pc_d;
        mis_q   <= mis_d;
`ifdef IF_DELAY_SLOT_EN
        target_q <= target_d;
`endif
    end

    assign o_imem_req   = req;
    assign o_imem_addr  = pc_q;
    assign o_valid      = valid & ~i_rst;
    assign o_pc         = pc_q;
    assign o_pcadd4     = pcadd4;
    assign o_misaligned = mis_q;

endmodule

// File: tb/tb_if_pc_ctrl.sv
// Directed bench for if_pc_ctrl; expectations follow IF_DELAY_SLOT_EN when defined.
module tb_if_pc_ctrl;

`ifdef IF_DELAY_SLOT_EN
    localparam bit DS = 1'b1;
`else
    localparam bit DS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        redir = 1'b0;
    logic [31:0] raddr = 32'h0;
    logic        ack = 1'b0;
    logic        req, valid, mis;
    logic [31:0] addr, pc, pcadd4;

    int n_cmp = 0;
    int n_err = 0;

    if_pc_ctrl #(.RESET_VECTOR(32'h0000_0100)) dut (
        .i_clk           (clk),
        .i_rst           (rst),
        .i_stall         (stall),
        .i_redirect      (redir),
        .i_redirect_addr (raddr),
        .o_imem_req      (req),
        .o_imem_addr     (addr),
        .i_imem_ack      (ack),
        .o_valid         (valid),
        .o_pc            (pc),
        .o_pcadd4        (pcadd4),
        .o_misaligned    (mis)
    );

    always #5 clk = ~clk;

    // Inputs change on the falling edge; outputs are checked 1ns later.
    task automatic step(input logic r, input logic s, input logic rd, input logic [31:0] ra,
                        input logic a);
        @(negedge clk);
        rst   = r;
        stall = s;
        redir = rd;
        raddr = ra;
        ack   = a;
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        // Reset cycle with ack high: nothing accepted, nothing requested
        step(1, 0, 0, 32'h0, 1);
        chk("rst_req", {31'b0, req}, 32'd0);
        chk("rst_valid", {31'b0, valid}, 32'd0);
        chk("rst_mis", {31'b0, mis}, 32'd0);
        // IDLE
        step(0, 0, 0, 32'h0, 1);
        chk("idle_req", {31'b0, req}, 32'd0);
        chk("idle_valid", {31'b0, valid}, 32'd0);
        // Sequential fetch from reset vector
        step(0, 0, 0, 32'h0, 1);
        chk("f0_req", {31'b0, req}, 32'd1);
        chk("f0_addr", addr, 32'h100);
        chk("f0_valid", {31'b0, valid}, 32'd1);
        chk("f0_pc", pc, 32'h100);
        chk("f0_pcadd4", pcadd4, 32'h104);
        step(0, 0, 0, 32'h0, 1);
        chk("f1_valid", {31'b0, valid}, 32'd1);
        chk("f1_pc", pc, 32'h104);
        // Three stall cycles at 0x108
        step(0, 1, 0, 32'h0, 1);
        chk("st0_addr", addr, 32'h108);
        chk("st0_req", {31'b0, req}, 32'd1);
        chk("st0_valid", {31'b0, valid}, 32'd0);
        step(0, 1, 0, 32'h0, 1);
        chk("st1_req", {31'b0, req}, 32'd0);
        chk("st1_valid", {31'b0, valid}, 32'd0);
        step(0, 1, 0, 32'h0, 1);
        chk("st2_req", {31'b0, req}, 32'd0);
        step(0, 0, 0, 32'h0, 1);
        chk("st3_req", {31'b0, req}, 32'd0);
        chk("st3_valid", {31'b0, valid}, 32'd0);
        step(0, 0, 0, 32'h0, 1);
        chk("refetch_valid", {31'b0, valid}, 32'd1);
        chk("refetch_pc", pc, 32'h108);
        // Misaligned redirect without ack: rejected, pulse next cycle
        step(0, 0, 1, 32'h0000_2002, 0);
        chk("mis_addr", addr, 32'h10C);
        chk("mis_now", {31'b0, mis}, 32'd0);
        chk("mis_valid", {31'b0, valid}, 32'd0);
        // Pulse visible here; aligned redirect to 0x2000 with ack at 0x10C
        step(0, 0, 1, 32'h0000_2000, 1);
        chk("mis_pulse", {31'b0, mis}, 32'd1);
        chk("rd_addr", addr, 32'h10C);
        chk("rd_valid", {31'b0, valid}, {31'b0, DS});
        step(0, 0, 0, 32'h0, 1);
        chk("mis_clear", {31'b0, mis}, 32'd0);
        chk("tgt_valid", {31'b0, valid}, 32'd1);
        chk("tgt_pc", pc, 32'h2000);
        // Redirect without ack at 0x2004
        step(0, 0, 1, 32'h0000_3000, 0);
        chk("rd2_addr", addr, 32'h2004);
        chk("rd2_valid", {31'b0, valid}, 32'd0);
        // Stall plus another redirect: ignored in DSLOT, otherwise the redirect wins
        step(0, 1, 1, 32'h0000_4000, 1);
        chk("s14_req", {31'b0, req}, DS ? 32'd0 : 32'd1);
        chk("s14_valid", {31'b0, valid}, 32'd0);
        step(0, 0, 0, 32'h0, 1);
        chk("s15_valid", {31'b0, valid}, 32'd1);
        chk("s15_pc", pc, DS ? 32'h2004 : 32'h4000);
        step(0, 0, 0, 32'h0, 1);
        chk("s16_valid", {31'b0, valid}, 32'd1);
        chk("s16_pc", pc, DS ? 32'h3000 : 32'h4004);
        // Redirect with ack to top of address space
        step(0, 0, 1, 32'hFFFF_FFFC, 1);
        chk("s17_valid", {31'b0, valid}, {31'b0, DS});
        step(0, 0, 0, 32'h0, 1);
        chk("wrap_valid", {31'b0, valid}, 32'd1);
        chk("wrap_pc", pc, 32'hFFFF_FFFC);
        chk("wrap_pcadd4", pcadd4, 32'h0000_0000);
        step(0, 0, 0, 32'h0, 1);
        chk("wrapped_valid", {31'b0, valid}, 32'd1);
        chk("wrapped_pc", pc, 32'h0000_0000);
        // Redirect without ack (enters DSLOT when enabled), then reset
        step(0, 0, 1, 32'h0000_0500, 0);
        chk("s20_valid", {31'b0, valid}, 32'd0);
        step(1, 0, 0, 32'h0, 1);
        chk("rst2_valid", {31'b0, valid}, 32'd0);
        chk("rst2_req", {31'b0, req}, 32'd0);
        step(0, 0, 0, 32'h0, 1);
        chk("idle2_req", {31'b0, req}, 32'd0);
        step(0, 0, 0, 32'h0, 1);
        chk("rv_valid", {31'b0, valid}, 32'd1);
        chk("rv_pc", pc, 32'h100);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
